// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and IF/ID register for a single-issue in-order pipeline.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall and bubble counters.
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_en,
    input  logic [31:0] i_redirect_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc4,
    output logic [31:0] o_id_instr,
    output logic        o_id_valid,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_bubble_cnt
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] id_pc_q;
    logic        id_valid_q;
    logic        id_valid_d;

    // Targets are word aligned; the low two bits of the redirect target carry no address.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (i_redirect_en) begin
            pc_d = {i_redirect_pc[31:2], 2'b00};
        end else if (i_stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        id_valid_d = 1'b1;
        if (i_redirect_en || i_flush) begin
            id_valid_d = 1'b0;
        end else if (i_stall) begin
            id_valid_d = id_valid_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC_ALIGNED;
            id_pc_q    <= RESET_PC;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            if (!i_stall) begin
                id_pc_q <= pc_q;
            end
        end
    end

    assign o_pc       = pc_q;
    assign o_id_pc    = id_pc_q;
    assign o_id_pc4   = id_pc_q + 32'd4;
    assign o_id_valid = id_valid_q;
    assign o_id_instr = id_valid_q ? i_instr : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (i_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!id_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`else
    assign o_stall_cnt  = 32'd0;
    assign o_bubble_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus, per-cycle reference model compare, pinned literal checks.
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redir_en = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc, id_pc, id_pc4, id_instr, stall_cnt, bubble_cnt;
    logic        id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect_en (redir_en),
        .i_redirect_pc (redir_pc),
        .i_instr       (instr),
        .o_pc          (pc),
        .o_id_pc       (id_pc),
        .o_id_pc4      (id_pc4),
        .o_id_instr    (id_instr),
        .o_id_valid    (id_valid),
        .o_stall_cnt   (stall_cnt),
        .o_bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Instruction memory stub: registered read, frozen by the shared stall net.
    always @(posedge clk) begin
        if (!stall) instr <= mem_word(pc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_id_pc = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_sc = 32'h0;
    logic [31:0] m_bc = 32'h0;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pc = 32'h0; m_id_pc = 32'h0; m_valid = 1'b0; m_sc = 32'h0; m_bc = 32'h0;
        end else begin
            logic [31:0] old_pc;
            logic        old_valid;
            old_pc    = m_pc;
            old_valid = m_valid;
            if (redir_en)    m_pc = redir_pc & 32'hFFFF_FFFC;
            else if (!stall) m_pc = old_pc + 32'd4;
            if (!stall) m_id_pc = old_pc;
            if (redir_en || flush) m_valid = 1'b0;
            else if (!stall)       m_valid = 1'b1;
            if (stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (!old_valid && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        end
        #1;
        check("model_pc", pc, m_pc);
        check("model_id_pc", id_pc, m_id_pc);
        check("model_id_pc4", id_pc4, m_id_pc + 32'd4);
        check("model_valid", {31'd0, id_valid}, {31'd0, m_valid});
        check("model_instr", id_instr, m_valid ? mem_word(m_id_pc) : NOP);
`ifdef FETCH_PERF_CNT_EN
        check("model_stall_cnt", stall_cnt, m_sc);
        check("model_bubble_cnt", bubble_cnt, m_bc);
`else
        check("model_stall_cnt", stall_cnt, 32'd0);
        check("model_bubble_cnt", bubble_cnt, 32'd0);
`endif
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [31:0] sc0;
    logic [31:0] exp_sc_delta;

    initial begin
        step(2);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_instr", id_instr, NOP);
        check("rst_cnt", stall_cnt | bubble_cnt, 32'd0);

        rst_n = 1'b1;
        #1 check("first_bubble", {31'd0, id_valid}, 32'd0);
        step(1);
        check("seq_pc1", pc, 32'h4);
        check("seq_id0", id_pc, 32'h0);
        check("seq_valid", {31'd0, id_valid}, 32'd1);
        check("seq_instr0", id_instr, 32'hDEAD_0000);
        step(1);
        check("seq_pc2", pc, 32'h8);
        check("seq_id1", id_pc, 32'h4);
        step(2);
        check("pre_stall_pc", pc, 32'h10);

        // Hold for three cycles at 0x10.
        sc0 = stall_cnt;
        stall = 1'b1;
        step(3);
        stall = 1'b0;
        check("stall_pc", pc, 32'h10);
        check("stall_id_pc", id_pc, 32'hC);
        check("stall_instr", id_instr, 32'hDEAD_000C);
`ifdef FETCH_PERF_CNT_EN
        exp_sc_delta = 32'd3;
`else
        exp_sc_delta = 32'd0;
`endif
        check("stall_cnt_delta", stall_cnt - sc0, exp_sc_delta);

        step(4);
        check("pre_redir_pc", pc, 32'h20);
        redir_en = 1'b1; redir_pc = 32'h203;
        step(1);
        redir_en = 1'b0;
        check("redir_pc", pc, 32'h200);
        check("redir_valid", {31'd0, id_valid}, 32'd0);
        check("redir_nop", id_instr, NOP);
        step(1);
        check("redir_id_pc", id_pc, 32'h200);
        check("redir_valid2", {31'd0, id_valid}, 32'd1);

        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_valid", {31'd0, id_valid}, 32'd0);
        check("flush_pc", pc, 32'h208);
        step(1);
        check("flush_recover", {31'd0, id_valid}, 32'd1);

        // Redirect while stalled.
        stall = 1'b1; redir_en = 1'b1; redir_pc = 32'h80;
        step(1);
        redir_en = 1'b0;
        check("sr_pc", pc, 32'h80);
        check("sr_valid", {31'd0, id_valid}, 32'd0);
        step(2);
        check("sr_hold_valid", {31'd0, id_valid}, 32'd0);
        stall = 1'b0;
        step(1);
        check("sr_id_pc", id_pc, 32'h80);
        check("sr_valid_after", {31'd0, id_valid}, 32'd1);
        check("sr_instr", id_instr, 32'hDEAD_0080);

        // Address wrap.
        redir_en = 1'b1; redir_pc = 32'hFFFF_FFFC;
        step(1);
        redir_en = 1'b0;
        step(1);
        check("wrap_pc", pc, 32'h0);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc4, 32'h0);

        // Asynchronous reset between edges, mid-stall.
        step(2);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_valid", {31'd0, id_valid}, 32'd0);
        check("arst_instr", id_instr, NOP);
        check("arst_cnt", stall_cnt | bubble_cnt, 32'd0);
        stall = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_arst_pc", pc, 32'h8);
        check("post_arst_id", id_pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the instruction presented on bubbles.
REQ-003 SHALL have i_clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have i_stall, input, 1, hazard stall: hold PC and IF/ID state; the same net drives the instruction memory's stall input.
REQ-006 SHALL have i_flush, input, 1, squash the instruction entering ID on the next edge.
REQ-007 SHALL have i_redirect_en, input, 1, taken branch/jump resolved downstream.
REQ-008 SHALL have i_redirect_pc, input, 32, the redirect target.
REQ-009 SHALL have i_instr, input, 32, the registered instruction-memory output, valid one cycle after the address.
REQ-010 SHALL have o_pc, output, 32, the fetch address to instruction memory.
REQ-011 SHALL have o_id_pc, output, 32, the PC of the instruction presented to ID.
REQ-012 SHALL have o_id_pc4, output, 32, o_id_pc + 4.
REQ-013 SHALL have o_id_instr, output, 32, the instruction presented to ID.
REQ-014 SHALL have o_id_valid, output, 1, meaning the ID slot holds a real instruction.
REQ-015 SHALL have o_stall_cnt, output, 32, the stall-cycle counter (see Configuration).
REQ-016 SHALL have o_bubble_cnt, output, 32, the bubble-cycle counter (see Configuration).

Function
REQ-017 SHALL hold pc_q (drives o_pc), id_pc_q and id_valid_q as registers; o_id_pc = id_pc_q.
REQ-018 SHALL force o_pc[1:0] = 2'b00; the redirect target is taken with bits [1:0] cleared.
REQ-019 SHALL compute next PC with the following priority:
- i_redirect_en -> i_redirect_pc.
- else i_stall -> hold.
- else pc_q + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
REQ-020 SHALL, on each edge with i_stall=0, latch id_pc_q <= pc_q, pairing it with the instruction the memory latches from the same address.
REQ-021 SHALL, on each edge with i_stall=1, hold id_pc_q.
REQ-022 SHALL set id_valid_q <= 0 on any edge with i_redirect_en=1 or i_flush=1, regardless of i_stall.
REQ-023 SHALL otherwise hold id_valid_q when i_stall=1, and set it to 1 when i_stall=0.
REQ-024 SHALL present o_id_instr = i_instr when o_id_valid=1, else NOP_INSTR (combinational mux, no extra latency).
REQ-025 SHALL have a fetch-to-ID latency of exactly one cycle: address on o_pc in cycle N, instruction and its PC at ID in cycle N+1.
REQ-026 SHALL, on redirect during stall, load the target next cycle with o_id_valid=0; the target instruction reaches ID one cycle after the stall releases.

Reset
REQ-027 SHALL, while i_rst_n=0, force the following asynchronously:
- pc_q = RESET_PC, id_pc_q = RESET_PC, id_valid_q = 0.
- o_id_instr = NOP_INSTR, counters = 0.
REQ-028 SHALL keep the first cycle after reset release a bubble (o_id_valid=0); the first valid instruction is RESET_PC, one cycle later.
REQ-029 SHALL, on reset assertion mid-stall or mid-redirect, discard the pending state immediately.

Configuration
REQ-030 SHALL, with macro FETCH_PERF_CNT_EN defined, implement the performance counters as follows:
- o_stall_cnt increments each cycle i_stall=1.
- o_bubble_cnt increments each cycle o_id_valid=0.
- Both saturate at 32'hFFFF_FFFF.
REQ-031 SHALL, without FETCH_PERF_CNT_EN, tie both counter outputs to 0 and infer no counter registers.

Verification
REQ-032 SHALL cover: reset release with RESET_PC=0, no stall -> o_pc 0,4,8,...; o_id_valid 0 then 1 with o_id_pc 0,4,8 trailing o_pc by one cycle.
REQ-033 SHALL cover: i_stall=1 for 3 cycles at o_pc=0x10 -> o_pc, o_id_pc, o_id_instr frozen; o_stall_cnt +3 (macro on).
REQ-034 SHALL cover: i_redirect_en=1, i_redirect_pc=0x203 at o_pc=0x20 -> next o_pc=0x200; o_id_valid=0 and o_id_instr=0x00000013 for one cycle; then o_id_pc=0x200.
REQ-035 SHALL cover: simultaneous i_stall=1 and i_redirect_en=1 (target 0x80) -> o_pc=0x80 next cycle; o_id_valid=0 until one cycle after stall drops.
REQ-036 SHALL cover: pc_q=0xFFFFFFFC, no stall -> o_pc wraps to 0x0; o_id_pc4 of that slot = 0x0.
REQ-037 SHALL cover: i_rst_n pulsed low mid-stream asynchronously (between edges) -> o_pc=RESET_PC and o_id_valid=0 immediately; counters cleared.
